fetch_request_unit: RTL and testbench

Sequential front-end and memory-request sequencer for the single-cycle MIPS datapath. Holds the PC, issues instruction fetches, and stalls on data-memory accesses flagged by the control unit until `dhit`. Computes the next PC from the control unit's `{JReg,PcSrc}` selection and latches halt. Sits directly upstream of the control unit, which decodes the instruction this block fetches, and consumes that decoder's `PcSrc`, `JReg`, `Halt`, `dMemREN` and `dMemWEN` outputs.

---
 rtl/fetch_request_unit.sv | 128 ++++++++++++
 tb/tb_fetch_request_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_request_unit.sv
// Fetch/request sequencer for the single-cycle MIPS datapath: owns the PC,
// issues instruction fetches, stalls on loads/stores until dhit, latches halt.
module fetch_request_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        PcSrc,
    input  logic        JReg,
    input  logic        Halt,
    input  logic        dMemREN,
    input  logic        dMemWEN,
    input  logic [31:0] Imm32,
    input  logic [25:0] JAddr,
    input  logic [31:0] RsData,
    output logic [31:0] imemaddr,
    output logic [31:0] pc_plus4,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        ir_load,
    output logic        instr_done,
    output logic        halted,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] npc_reg, npc_next;
    logic        rd_flag_reg, rd_flag_next;
    logic        wr_flag_reg, wr_flag_next;
    logic [31:0] retire_reg, retire_next;
    logic [31:0] pc4;
    logic [31:0] target_pc;

    assign pc4 = pc_reg + 32'd4;

    always_comb begin
        case ({JReg, PcSrc})
            2'b00:   target_pc = pc4;
            2'b01:   target_pc = pc4 + {Imm32[29:0], 2'b00};
            2'b10:   target_pc = {RsData[31:2], 2'b00};
            default: target_pc = {pc4[31:28], JAddr, 2'b00};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= FETCH;
            pc_reg      <= PC_INIT;
            npc_reg     <= 32'd0;
            rd_flag_reg <= 1'b0;
            wr_flag_reg <= 1'b0;
            retire_reg  <= 32'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            npc_reg     <= npc_next;
            rd_flag_reg <= rd_flag_next;
            wr_flag_reg <= wr_flag_next;
            retire_reg  <= retire_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        npc_next     = npc_reg;
        rd_flag_next = rd_flag_reg;
        wr_flag_next = wr_flag_reg;
        retire_next  = retire_reg;
        ir_load      = 1'b0;
        instr_done   = 1'b0;
        case (state_reg)
            FETCH: begin
                if (ihit) begin
                    ir_load = 1'b1;
                    if (Halt) begin
                        state_next = HALTED;
                    end else if (dMemWEN || dMemREN) begin
                        // A store wins when the decoder flags both directions.
                        wr_flag_next = dMemWEN;
                        rd_flag_next = dMemREN & ~dMemWEN;
                        npc_next     = target_pc;
                        state_next   = DATA;
                    end else begin
                        pc_next     = target_pc;
                        instr_done  = 1'b1;
                        retire_next = retire_reg + 32'd1;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    pc_next     = npc_reg;
                    instr_done  = 1'b1;
                    retire_next = retire_reg + 32'd1;
                    state_next  = FETCH;
                end
            end
            HALTED: begin
            end
            default: state_next = FETCH;
        endcase
        // Reset beats a same-cycle hit, so nothing may be written back.
        if (RST) begin
            ir_load    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign imemaddr     = pc_reg;
    assign pc_plus4     = pc4;
    assign iREN         = (state_reg == FETCH);
    assign dREN         = (state_reg == DATA) && rd_flag_reg;
    assign dWEN         = (state_reg == DATA) && wr_flag_reg;
    assign halted       = (state_reg == HALTED);
    assign retire_count = retire_reg;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Randomized scoreboard bench for fetch_request_unit: the stimulus side models
// each instruction's retirement, a negedge monitor matches every instr_done.
module tb_fetch_request_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0;
    logic        PcSrc = 1'b0, JReg = 1'b0, Halt = 1'b0;
    logic        dMemREN = 1'b0, dMemWEN = 1'b0;
    logic [31:0] Imm32 = 32'd0;
    logic [25:0] JAddr = 26'd0;
    logic [31:0] RsData = 32'd0;
    logic [31:0] imemaddr, pc_plus4, retire_count;
    logic        iREN, dREN, dWEN, ir_load, instr_done, halted;

    always #5 CLK = ~CLK;

    fetch_request_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .PcSrc(PcSrc), .JReg(JReg), .Halt(Halt),
        .dMemREN(dMemREN), .dMemWEN(dMemWEN),
        .Imm32(Imm32), .JAddr(JAddr), .RsData(RsData),
        .imemaddr(imemaddr), .pc_plus4(pc_plus4),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .ir_load(ir_load), .instr_done(instr_done),
        .halted(halted), .retire_count(retire_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] count;
    } ret_t;

    ret_t        exp_q[$];
    ret_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_m     = PC_INIT;
    logic [31:0] count_m  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference next-PC, written from the selection rules with plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] pc, input bit jr, input bit br,
                                              input logic [31:0] imm, input logic [25:0] ja,
                                              input logic [31:0] rs);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jr && br) return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
        if (jr)       return rs & 32'hFFFF_FFFC;
        if (br)       return seq + imm * 32'd4;
        return seq;
    endfunction

    task automatic junk();
        ihit    = 1'($urandom);
        dhit    = 1'($urandom);
        PcSrc   = 1'($urandom);
        JReg    = 1'($urandom);
        Halt    = 1'($urandom);
        dMemREN = 1'($urandom);
        dMemWEN = 1'($urandom);
        Imm32   = $urandom;
        JAddr   = 26'($urandom);
        RsData  = $urandom;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        junk();
        ihit = 1'b1;
        dhit = 1'b1;
        @(posedge CLK); #1;
        RST  = 1'b0;
        ihit = 1'b0;
        dhit = 1'b0;
        exp_q.delete();
        pc_m    = PC_INIT;
        count_m = 32'd0;
        @(negedge CLK);
        chk("rst_pc", imemaddr, PC_INIT);
        chk("rst_iren", 32'(iREN), 32'd1);
        chk("rst_dren", 32'(dREN), 32'd0);
        chk("rst_dwen", 32'(dWEN), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", retire_count, 32'd0);
        @(posedge CLK); #1;
    endtask

    task automatic idle_check(input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        junk();
        ihit = 1'b0;
        @(negedge CLK);
        chk("idle_pc", imemaddr, exp_pc);
        chk("idle_count", retire_count, exp_cnt);
        @(posedge CLK); #1;
    endtask

    // One instruction: iwait fetch-stall cycles, the ihit cycle, and for
    // loads/stores dwait DATA cycles before dhit (or a reset if abort).
    task automatic do_instr(input bit halt, input bit ren, input bit wen, input bit jr, input bit br,
                            input logic [31:0] imm, input logic [25:0] ja, input logic [31:0] rs,
                            input int iwait, input int dwait, input bit abort);
        logic [31:0] npc;
        bit          mem;
        mem = ren || wen;
        npc = model_npc(pc_m, jr, br, imm, ja, rs);
        for (int i = 0; i < iwait; i++) begin
            junk();
            ihit = 1'b0;
            @(negedge CLK);
            chk("stall_pc", imemaddr, pc_m);
            chk("stall_iren", 32'(iREN), 32'd1);
            @(posedge CLK); #1;
        end
        ihit = 1'b1; dhit = 1'($urandom);
        Halt = halt; dMemREN = ren; dMemWEN = wen; JReg = jr; PcSrc = br;
        Imm32 = imm; JAddr = ja; RsData = rs;
        if (!halt && !mem) exp_q.push_back('{pc_m, count_m});
        @(negedge CLK);
        chk("fetch_pc", imemaddr, pc_m);
        chk("pc_plus4", pc_plus4, pc_m + 32'd4);
        chk("ir_load", 32'(ir_load), 32'd1);
        chk("fetch_iren", 32'(iREN), 32'd1);
        @(posedge CLK); #1;
        ihit = 1'b0;
        if (halt) return;
        if (mem) begin
            for (int i = 0; i < dwait; i++) begin
                junk();
                dhit = 1'b0;
                @(negedge CLK);
                chk("data_dren", 32'(dREN), 32'(ren && !wen));
                chk("data_dwen", 32'(dWEN), 32'(wen));
                chk("data_iren", 32'(iREN), 32'd0);
                chk("data_pc", imemaddr, pc_m);
                @(posedge CLK); #1;
            end
            if (abort) begin
                RST = 1'b1;
                junk();
                dhit = 1'b1;
                @(posedge CLK); #1;
                RST  = 1'b0;
                ihit = 1'b0;
                dhit = 1'b0;
                pc_m    = PC_INIT;
                count_m = 32'd0;
                @(negedge CLK);
                chk("abort_dwen", 32'(dWEN), 32'd0);
                chk("abort_dren", 32'(dREN), 32'd0);
                chk("abort_pc", imemaddr, PC_INIT);
                chk("abort_count", retire_count, 32'd0);
                @(posedge CLK); #1;
                return;
            end
            junk();
            dhit = 1'b1;
            exp_q.push_back('{pc_m, count_m});
            @(negedge CLK);
            chk("dhit_dren", 32'(dREN), 32'(ren && !wen));
            chk("dhit_dwen", 32'(dWEN), 32'(wen));
            @(posedge CLK); #1;
            dhit = 1'b0;
        end
        pc_m    = npc;
        count_m = count_m + 32'd1;
    endtask

    task automatic jump_to(input logic [31:0] target);
        do_instr(0, 0, 0, 1, 0, 32'd0, 26'd0, target, 0, 0, 0);
    endtask

    // Scoreboard monitor: every retirement must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && instr_done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_retire", 32'(instr_done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("retire_pc", imemaddr, mon_e.pc);
                chk("retire_count", retire_count, mon_e.count);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int kind;
        do_reset();

        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0, 0, 0, 0);
        idle_check(32'h0000_000C, 32'd3);

        jump_to(32'h0000_0010);
        do_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 26'd0, 32'd0, 0, 0, 0);
        idle_check(32'h0000_000C, count_m);
        do_instr(0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h0000_0103, 1, 0, 0);
        idle_check(32'h0000_0100, count_m);

        jump_to(32'h1000_0004);
        do_instr(0, 0, 0, 1, 1, 32'd0, 26'h0000040, 32'd0, 0, 0, 0);
        idle_check(32'h1000_0100, count_m);

        jump_to(32'h0000_0020);
        do_instr(0, 1, 0, 0, 0, 32'd0, 26'd0, 32'd0, 0, 3, 0);
        idle_check(32'h0000_0024, count_m);

        do_instr(0, 1, 1, 0, 0, 32'd0, 26'd0, 32'd0, 0, 2, 0);
        do_instr(0, 1, 1, 0, 0, 32'd0, 26'd0, 32'd0, 0, 1, 1);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            do_instr(0, kind == 2 || (kind == 3 && 1'($urandom)), kind == 3,
                     1'($urandom), 1'($urandom), $urandom, 26'($urandom), $urandom,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
        end
        idle_check(pc_m, count_m);

        jump_to(32'h0000_0040);
        do_instr(1, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            junk();
            @(negedge CLK);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_iren", 32'(iREN), 32'd0);
            chk("halt_dreq", 32'({dREN, dWEN}), 32'd0);
            chk("halt_pc", imemaddr, 32'h0000_0040);
            chk("halt_count", retire_count, count_m);
            @(posedge CLK); #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        do_reset();
        do_instr(0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0, 0, 0, 0);
        idle_check(32'h0000_0004, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
